// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and sequencer state encoding
package alu_pkg;

  localparam logic [3:0] OP_ANDR = 4'b0000;
  localparam logic [3:0] OP_XORR = 4'b0001;
  localparam logic [3:0] OP_ORR  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_GT   = 4'b1010;
  localparam logic [3:0] OP_LT   = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_BIC  = 4'b1110;
  localparam logic [3:0] OP_NOT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU, response and debug signal bundle
interface alu_cmd_sequencer_if #(
  parameter int REG_AW = 2
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [3:0]        cmd_opcode;
  logic [REG_AW-1:0] cmd_dst;
  logic [REG_AW-1:0] cmd_srca;
  logic [REG_AW-1:0] cmd_srcb;
  logic              cmd_imm_en;
  logic [7:0]        cmd_imm;

  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [3:0]        alu_opcode;
  logic [7:0]        alu_result;
  logic [7:0]        alu_carry;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_result;
  logic [7:0]        rsp_carry;

  logic [REG_AW-1:0] dbg_sel;
  logic [7:0]        dbg_data;

  modport slave (
    input  cmd_valid, cmd_load, cmd_opcode, cmd_dst, cmd_srca, cmd_srcb,
           cmd_imm_en, cmd_imm, alu_result, alu_carry, rsp_ready, dbg_sel,
    output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result,
           rsp_carry, dbg_data
  );

  modport master (
    output cmd_valid, cmd_load, cmd_opcode, cmd_dst, cmd_srca, cmd_srcb,
           cmd_imm_en, cmd_imm, alu_result, alu_carry, rsp_ready, dbg_sel,
    input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result,
           rsp_carry, dbg_data
  );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x 8 register file, one write port, three read ports
module alu_regfile #(
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [7:0]        rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [7:0]        rdata_b,
  input  logic [REG_AW-1:0] raddr_d,
  output logic [7:0]        rdata_d
);

  localparam int NREGS = 2 ** REG_AW;

  logic [7:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command sequencer feeding an external 8-bit ALU
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus
);

  seq_state_t        state, state_nxt;
  logic [REG_AW-1:0] dst_q;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [7:0]        rf_wdata;
  logic [7:0]        rd_a, rd_b;

  alu_regfile #(.REG_AW(REG_AW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (bus.cmd_srca),
    .rdata_a (rd_a),
    .raddr_b (bus.cmd_srcb),
    .rdata_b (rd_b),
    .raddr_d (bus.dbg_sel),
    .rdata_d (bus.dbg_data)
  );

  assign bus.cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Operands are sampled at acceptance, so a write from the same command never aliases them.
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_waddr  = dst_q;
    rf_wdata  = bus.alu_result;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_load) begin
            rf_we     = 1'b1;
            rf_waddr  = bus.cmd_dst;
            rf_wdata  = bus.cmd_imm;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        rf_we     = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a      <= 8'h00;
      bus.alu_b      <= 8'h00;
      bus.alu_opcode <= 4'h0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= 8'h00;
      bus.rsp_carry  <= 8'h00;
      dst_q          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_load) begin
              bus.rsp_result <= bus.cmd_imm;
              bus.rsp_carry  <= 8'h00;
              bus.rsp_valid  <= 1'b1;
            end else begin
              bus.alu_a      <= rd_a;
              bus.alu_b      <= bus.cmd_imm_en ? bus.cmd_imm : rd_b;
              bus.alu_opcode <= bus.cmd_opcode;
              dst_q          <= bus.cmd_dst;
            end
          end
        end
        ST_ISSUE: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_carry  <= bus.alu_carry;
          bus.rsp_valid  <= 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
